aes_iter_decrypt: RTL and testbench



---
 rtl/aes_iter_decrypt.sv | 238 +++++++++++++++++++++++
 tb/tb_aes_iter_decrypt.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_decrypt.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys derived on the fly.
// Define AES_DEC_KEYCACHE_EN to remember the last key and its rk10 so a repeated key skips the KEY phase.
module aes_iter_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] KEY  = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Undo xtime: an odd value can only come from the 0x1b reduction of a high bit.
  function automatic logic [7:0] invXt(input logic [7:0] a);
    return a[0] ? ({1'b0, a[7:1]} ^ 8'h8d) : {1'b0, a[7:1]};
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); zero maps to zero.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] p, sq;
    p  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gfMul(sq, sq);
      p  = gfMul(p, sq);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    a = gfInv(x);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subRotWord(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] expandKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] invertKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ subRotWord(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // b[15] is byte 0; row r of each column is rotated right by r.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [15:0][7:0] b;
    b = s;
    return {b[15], b[2], b[5], b[8], b[11], b[14], b[1], b[4],
            b[7], b[10], b[13], b[0], b[3], b[6], b[9], b[12]};
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] w);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      m9[i] = xt(xt(xt(a[i]))) ^ a[i];
      mb[i] = xt(xt(xt(a[i]))) ^ xt(a[i]) ^ a[i];
      md[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ a[i];
      me[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [1:0]   fsmQ, fsmD;
  logic [127:0] stateQ, stateD, keyQ, keyD, ptQ, ptD;
  logic [7:0]   rconQ, rconD;
  logic [3:0]   roundQ, roundD;
  logic [127:0] shifted, subbed, addKey, mixed, fwdKey, invKey;

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] cacheKeyQ, cacheKeyD, cacheRkQ, cacheRkD;
  logic         cacheValidQ, cacheValidD, cacheHit;
  assign cacheHit = cacheValidQ && (key == cacheKeyQ);
`endif

  assign shifted = invShiftRows(stateQ);
  assign fwdKey  = expandKey(keyQ, rconQ);
  assign invKey  = invertKey(keyQ, rconQ);
  assign addKey  = subbed ^ invKey;

  for (genvar g = 0; g < 16; g++) begin : gInvSub
    assign subbed[8*g +: 8] = invSbox(shifted[8*g +: 8]);
  end
  for (genvar g = 0; g < 4; g++) begin : gInvMix
    assign mixed[32*g +: 32] = invMixCol(addKey[32*g +: 32]);
  end

  assign in_ready  = (fsmQ == IDLE);
  assign busy      = (fsmQ != IDLE);
  assign out_valid = (fsmQ == DONE);
  assign plaintext = ptQ;

  always_comb begin
    fsmD   = fsmQ;
    stateD = stateQ;
    keyD   = keyQ;
    ptD    = ptQ;
    rconD  = rconQ;
    roundD = roundQ;
`ifdef AES_DEC_KEYCACHE_EN
    cacheKeyD   = cacheKeyQ;
    cacheRkD    = cacheRkQ;
    cacheValidD = cacheValidQ;
`endif
    case (fsmQ)
      IDLE: if (in_valid) begin
`ifdef AES_DEC_KEYCACHE_EN
        if (cacheHit) begin
          stateD = ciphertext ^ cacheRkQ;
          keyD   = cacheRkQ;
          rconD  = 8'h36;
          roundD = 4'd9;
          fsmD   = DEC;
        end else begin
          stateD      = ciphertext;
          keyD        = key;
          rconD       = 8'h01;
          roundD      = 4'd0;
          fsmD        = KEY;
          cacheKeyD   = key;
          cacheValidD = 1'b0;
        end
`else
        stateD = ciphertext;
        keyD   = key;
        rconD  = 8'h01;
        roundD = 4'd0;
        fsmD   = KEY;
`endif
      end
      // rcon 0x36 marks the step that produces rk10; it is kept for the first inverse step.
      KEY: begin
        keyD = fwdKey;
        if (rconQ == 8'h36) begin
          stateD = stateQ ^ fwdKey;
          roundD = 4'd9;
          fsmD   = DEC;
`ifdef AES_DEC_KEYCACHE_EN
          cacheRkD    = fwdKey;
          cacheValidD = 1'b1;
`endif
        end else begin
          rconD = xt(rconQ);
        end
      end
      DEC: begin
        keyD  = invKey;
        rconD = invXt(rconQ);
        if (roundQ == 4'd0) begin
          stateD = addKey;
          ptD    = addKey;
          fsmD   = DONE;
        end else begin
          stateD = mixed;
          roundD = roundQ - 4'd1;
        end
      end
      DONE: if (out_ready) fsmD = IDLE;
      default: fsmD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsmQ   <= IDLE;
      stateQ <= '0;
      keyQ   <= '0;
      ptQ    <= '0;
      rconQ  <= '0;
      roundQ <= '0;
    end else begin
      fsmQ   <= fsmD;
      stateQ <= stateD;
      keyQ   <= keyD;
      ptQ    <= ptD;
      rconQ  <= rconD;
      roundQ <= roundD;
    end
  end

`ifdef AES_DEC_KEYCACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cacheKeyQ   <= '0;
      cacheRkQ    <= '0;
      cacheValidQ <= 1'b0;
    end else begin
      cacheKeyQ   <= cacheKeyD;
      cacheRkQ    <= cacheRkD;
      cacheValidQ <= cacheValidD;
    end
  end
`endif

endmodule

// File: tb/tb_aes_iter_decrypt.sv
// Self-checking bench for aes_iter_decrypt: FIPS-197 vectors plus random jobs against a table-driven AES model.
// Expected latency follows AES_DEC_KEYCACHE_EN when the bench is built with that macro.
module tb_aes_iter_decrypt;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ciphertext, key, plaintext;
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sboxT [256];
  logic [7:0]   invSboxT [256];
  bit           mValid = 1'b0;
  logic [127:0] mKey = '0;

  always #5 clk = ~clk;

  aes_iter_decrypt dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] mulGf(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the generator-3 walk: p runs over all nonzero elements, q tracks 1/p.
  task automatic buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxT[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxT[0] = 8'h63;
    for (int i = 0; i < 256; i++) invSboxT[sboxT[i]] = 8'(i);
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] k, input logic [127:0] c);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxT[tmp[31:24]], sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = mulGf(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ 8'(w[40 + i/4] >> (24 - 8*(i%4)));
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[4*col+row] = invSboxT[s[4*((col - row + 4) % 4) + row]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ 8'(w[4*rnd + i/4] >> (24 - 8*(i%4)));
      if (rnd > 0) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = mulGf(a0, 8'h0e) ^ mulGf(a1, 8'h0b) ^ mulGf(a2, 8'h0d) ^ mulGf(a3, 8'h09);
          s[4*col+1] = mulGf(a0, 8'h09) ^ mulGf(a1, 8'h0e) ^ mulGf(a2, 8'h0b) ^ mulGf(a3, 8'h0d);
          s[4*col+2] = mulGf(a0, 8'h0d) ^ mulGf(a1, 8'h09) ^ mulGf(a2, 8'h0e) ^ mulGf(a3, 8'h0b);
          s[4*col+3] = mulGf(a0, 8'h0b) ^ mulGf(a1, 8'h0d) ^ mulGf(a2, 8'h09) ^ mulGf(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Latency the job being accepted should see, updating the modelled key cache.
  function automatic int modelAccept(input logic [127:0] k);
    if (CACHE_ON && mValid && k == mKey) return 10;
    mKey   = k;
    mValid = 1'b1;
    return 20;
  endfunction

  task automatic waitResult(input int expLat, input logic [127:0] expPt, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput({tag, ".latency"}, 128'(lat), 128'(expLat));
    checkOutput({tag, ".plaintext"}, plaintext, expPt);
  endtask

  task automatic finishJob(input int readyDelay, input logic [127:0] expPt, input string tag);
    for (int i = 0; i < readyDelay; i++) begin
      tick();
      checkOutput({tag, ".holdValid"}, 128'(out_valid), 128'd1);
      checkOutput({tag, ".holdPt"}, plaintext, expPt);
      checkOutput({tag, ".holdInReady"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, ".dropValid"}, 128'(out_valid), 128'd0);
    checkOutput({tag, ".idleReady"}, 128'(in_ready), 128'd1);
    checkOutput({tag, ".ptKept"}, plaintext, expPt);
  endtask

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c, input logic [127:0] expPt,
                               input int readyDelay, input bit scramble, input string tag);
    int expLat;
    expLat     = modelAccept(k);
    key        = k;
    ciphertext = c;
    in_valid   = 1'b1;
    out_ready  = (readyDelay == 0);
    checkOutput({tag, ".inReady"}, 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      key        = rand128();
      ciphertext = rand128();
    end
    checkOutput({tag, ".busy"}, 128'(busy), 128'd1);
    waitResult(expLat, expPt, tag);
    finishJob(readyDelay, expPt, tag);
  endtask

  task automatic backpressure();
    logic [127:0] c2;
    int lat1, lat2;
    c2         = rand128();
    lat1       = modelAccept(C1_KEY);
    key        = C1_KEY;
    ciphertext = C1_CT;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    tick();
    ciphertext = c2;
    waitResult(lat1, C1_PT, "bp1");
    for (int i = 0; i < 7; i++) begin
      tick();
      checkOutput("bp1.holdPt", plaintext, C1_PT);
      checkOutput("bp1.holdInReady", 128'(in_ready), 128'd0);
      checkOutput("bp1.holdValid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp1.dropValid", 128'(out_valid), 128'd0);
    checkOutput("bp1.idleReady", 128'(in_ready), 128'd1);
    checkOutput("bp1.idleBusy", 128'(busy), 128'd0);
    lat2 = modelAccept(C1_KEY);
    tick();
    in_valid = 1'b0;
    checkOutput("bp2.accepted", 128'(busy), 128'd1);
    waitResult(lat2, refDecrypt(C1_KEY, c2), "bp2");
    finishJob(0, refDecrypt(C1_KEY, c2), "bp2");
  endtask

  task automatic resetMidJob();
    logic [127:0] k, c;
    int lat;
    bit sawValid;
    k          = rand128();
    c          = rand128();
    lat        = modelAccept(k);
    key        = k;
    ciphertext = c;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (lat - 5) tick();
    checkOutput("rst.busyBefore", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst.outValid", 128'(out_valid), 128'd0);
    checkOutput("rst.busy", 128'(busy), 128'd0);
    checkOutput("rst.inReady", 128'(in_ready), 128'd1);
    checkOutput("rst.plaintext", plaintext, 128'd0);
    tick();
    rst    = 1'b0;
    mValid = 1'b0;
    sawValid = 1'b0;
    repeat (25) begin
      tick();
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("rst.noValidAfter", 128'(sawValid), 128'd0);
    checkOutput("rst.ptStillZero", plaintext, 128'd0);
  endtask

  initial begin
    logic [127:0] k, c, prevK;
    buildSbox();
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    key        = '0;
    ciphertext = '0;
    tick();
    checkOutput("reset.inReady", 128'(in_ready), 128'd1);
    checkOutput("reset.outValid", 128'(out_valid), 128'd0);
    checkOutput("reset.busy", 128'(busy), 128'd0);
    checkOutput("reset.plaintext", plaintext, 128'd0);
    tick();
    rst = 1'b0;
    tick();

    applyStimulus(C1_KEY, C1_CT, C1_PT, 0, 1'b0, "c1");
    applyStimulus(B_KEY, B_CT, B_PT, 2, 1'b0, "appB");
    k = rand128();
    c = rand128();
    applyStimulus(k, c, refDecrypt(k, c), 1, 1'b1, "latchOnce");
    backpressure();
    resetMidJob();
    applyStimulus(C1_KEY, C1_CT, C1_PT, 0, 1'b0, "c1AfterReset");
    applyStimulus(C1_KEY, C1_CT, C1_PT, 0, 1'b0, "c1Repeat");
    applyStimulus(B_KEY, B_CT, B_PT, 0, 1'b0, "newKey");

    prevK = B_KEY;
    for (int j = 0; j < 10; j++) begin
      k = ($urandom_range(2) == 0) ? prevK : rand128();
      c = rand128();
      applyStimulus(k, c, refDecrypt(k, c), int'($urandom_range(3)), 1'($urandom_range(1)),
                    $sformatf("rnd%0d", j));
      prevK = k;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
